// File: rtl/reg_bank_ctrl.sv
// Register bank R0..R7 with a small multi-cycle controller that steers the
// operand bus mux and writes bus or ALU results back into the bank.
module reg_bank_ctrl #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [8:0]        instr,
  input  logic [DATA_W-1:0] bus_in,
  output logic [3:0]        mux_sel,
  output logic [DATA_W-1:0] reg0,
  output logic [DATA_W-1:0] reg1,
  output logic [DATA_W-1:0] reg2,
  output logic [DATA_W-1:0] reg3,
  output logic [DATA_W-1:0] reg4,
  output logic [DATA_W-1:0] reg5,
  output logic [DATA_W-1:0] reg6,
  output logic [DATA_W-1:0] reg7,
  output logic              done,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    T1   = 2'd1,
    T2   = 2'd2,
    T3   = 2'd3
  } state_t;

  localparam logic [3:0] SEL_IMM = 4'd8;

  state_t            state;
  state_t            state_nxt;
  logic [8:0]        ir;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] g;
  logic [DATA_W-1:0] r [8];

  logic [2:0] op;
  logic [2:0] rx;
  logic [2:0] ry;
  logic       is_mv;
  logic       is_mvi;
  logic       is_alu;
  logic       is_nop;

  logic              ld_ir;
  logic              ld_a;
  logic              ld_g;
  logic              wr_en;
  logic              wr_src_g;
  logic [DATA_W-1:0] wr_data;

  assign op = ir[8:6];
  assign rx = ir[5:3];
  assign ry = ir[2:0];

  assign is_nop = op[2];
  assign is_mv  = (op == 3'b000);
  assign is_mvi = (op == 3'b001);
  assign is_alu = (op[2:1] == 2'b01);

  // Outputs depend only on registered state and IR.
  always_comb begin
    state_nxt = state;
    mux_sel   = 4'd0;
    done      = 1'b0;
    ld_ir     = 1'b0;
    ld_a      = 1'b0;
    ld_g      = 1'b0;
    wr_en     = 1'b0;
    wr_src_g  = 1'b0;
    unique case (state)
      IDLE: begin
        if (run) begin
          ld_ir     = 1'b1;
          state_nxt = T1;
        end
      end
      T1: begin
        unique case (1'b1)
          is_nop: begin
            done      = 1'b1;
            state_nxt = IDLE;
          end
          is_mv: begin
            mux_sel   = {1'b0, ry};
            wr_en     = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
          end
          is_mvi: begin
            mux_sel   = SEL_IMM;
            wr_en     = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
          end
          is_alu: begin
            mux_sel   = {1'b0, rx};
            ld_a      = 1'b1;
            state_nxt = T2;
          end
          default: state_nxt = IDLE;
        endcase
      end
      T2: begin
        mux_sel   = {1'b0, ry};
        ld_g      = 1'b1;
        state_nxt = T3;
      end
      T3: begin
        wr_en     = 1'b1;
        wr_src_g  = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy    = (state != IDLE);
  assign wr_data = wr_src_g ? g : bus_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ir    <= '0;
      a     <= '0;
      g     <= '0;
      for (int i = 0; i < 8; i++) r[i] <= '0;
    end else begin
      state <= state_nxt;
      if (ld_ir) ir <= instr;
      if (ld_a)  a  <= bus_in;
      // op[0] distinguishes sub (011) from add (010)
      if (ld_g)  g  <= op[0] ? a - bus_in : a + bus_in;
      if (wr_en) r[rx] <= wr_data;
    end
  end

  assign reg0 = r[0];
  assign reg1 = r[1];
  assign reg2 = r[2];
  assign reg3 = r[3];
  assign reg4 = r[4];
  assign reg5 = r[5];
  assign reg6 = r[6];
  assign reg7 = r[7];

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Scoreboard bench for reg_bank_ctrl: models the operand mux on bus_in
// and checks each completed instruction against hand-computed results.
module tb_reg_bank_ctrl;

  localparam int DW = 16;

  typedef struct {
    string      name;
    logic [3:0] msel;
    logic       wr;
    logic [2:0] rx;
    logic [DW-1:0] val;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic [8:0]    instr = '0;
  logic [DW-1:0] im_d = '0;
  logic [DW-1:0] bus_in;
  logic [3:0]    mux_sel;
  logic [DW-1:0] reg0, reg1, reg2, reg3;
  logic [DW-1:0] reg4, reg5, reg6, reg7;
  logic          done;
  logic          busy;

  logic [DW-1:0] r [8];
  logic [DW-1:0] m [8];
  exp_t q [$];
  int checks = 0;
  int errors = 0;

  reg_bank_ctrl #(.DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .instr(instr), .bus_in(bus_in),
    .mux_sel(mux_sel),
    .reg0(reg0), .reg1(reg1), .reg2(reg2),
    .reg3(reg3), .reg4(reg4), .reg5(reg5),
    .reg6(reg6), .reg7(reg7),
    .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  assign r[0] = reg0;
  assign r[1] = reg1;
  assign r[2] = reg2;
  assign r[3] = reg3;
  assign r[4] = reg4;
  assign r[5] = reg5;
  assign r[6] = reg6;
  assign r[7] = reg7;

  always_comb begin
    bus_in = im_d;
    if (mux_sel < 4'd8) bus_in = r[mux_sel[2:0]];
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // Monitor: every done cycle pops one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected none");
        end else begin
          e = q.pop_front();
          chk({e.name, "_done_sel"}, 32'(mux_sel), 32'(e.msel));
          @(posedge clk);
          #1;
          if (e.wr) m[e.rx] = e.val;
          for (int i = 0; i < 8; i++)
            chk($sformatf("%s_r%0d", e.name, i),
                32'(r[i]), 32'(m[i]));
        end
      end
    end
  end

  task automatic issue(input string name,
                       input logic [8:0] ins,
                       input logic [DW-1:0] imd,
                       input int n,
                       input logic [11:0] seq,
                       input logic wr,
                       input logic [DW-1:0] val,
                       input bit intr,
                       input logic [8:0] ins2);
    exp_t e;
    e.name = name;
    e.msel = seq[(n-1)*4 +: 4];
    e.wr   = wr;
    e.rx   = ins[5:3];
    e.val  = val;
    q.push_back(e);
    @(negedge clk);
    instr = ins;
    im_d  = imd;
    run   = 1'b1;
    @(posedge clk);
    #1;
    run = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 2) run = 1'b0;
      chk($sformatf("%s_sel%0d", name, k),
          32'(mux_sel), 32'(seq[k*4 +: 4]));
      chk($sformatf("%s_busy%0d", name, k),
          32'(busy), 32'd1);
      if (intr && k == 1) begin
        instr = ins2;
        im_d  = 16'hAAAA;
        run   = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) m[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++)
      chk($sformatf("rst_r%0d", i), 32'(r[i]), 32'd0);
    chk("rst_sel", 32'(mux_sel), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue("mvi_r2", 9'b001_010_000, 16'h1234, 1,
          12'h008, 1'b1, 16'h1234, 1'b0, '0);
    issue("mv_r5", 9'b000_101_010, 16'h0000, 1,
          12'h002, 1'b1, 16'h1234, 1'b0, '0);
    issue("add_r2", 9'b010_010_101, 16'h0000, 3,
          12'h052, 1'b1, 16'h2468, 1'b0, '0);
    issue("sub_r0", 9'b011_000_010, 16'h0000, 3,
          12'h020, 1'b1, 16'hDB98, 1'b0, '0);
    issue("mvi_r7", 9'b001_111_000, 16'hFFFF, 1,
          12'h008, 1'b1, 16'hFFFF, 1'b0, '0);
    issue("mvi_r1", 9'b001_001_000, 16'h0001, 1,
          12'h008, 1'b1, 16'h0001, 1'b0, '0);
    issue("add_wrap", 9'b010_111_001, 16'h0000, 3,
          12'h017, 1'b1, 16'h0000, 1'b0, '0);
    issue("add_busy_run", 9'b010_010_010, 16'h0000, 3,
          12'h022, 1'b1, 16'h48D0, 1'b1, 9'b001_110_000);
    repeat (3) @(negedge clk);
    chk("post_run_idle", 32'(busy), 32'd0);
    chk("post_run_r6", 32'(reg6), 32'd0);
    issue("nop", 9'b100_011_101, 16'h0000, 1,
          12'h000, 1'b0, 16'h0000, 1'b0, '0);
    issue("mv_r3_r3", 9'b000_011_011, 16'h0000, 1,
          12'h003, 1'b1, 16'h0000, 1'b0, '0);
    issue("mvi_r4", 9'b001_100_000, 16'h0005, 1,
          12'h008, 1'b1, 16'h0005, 1'b0, '0);

    @(negedge clk);
    instr = 9'b010_100_100;
    run   = 1'b1;
    @(posedge clk);
    #1;
    run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_t2", 32'(mux_sel), 32'd4);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) m[i] = '0;
    for (int i = 0; i < 8; i++)
      chk($sformatf("abort_r%0d", i), 32'(r[i]), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sel", 32'(mux_sel), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort_r4_after", 32'(reg4), 32'd0);
    chk("abort_idle_after", 32'(busy), 32'd0);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
